// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, transmitter FSM encoding, default baud divisor
// and a parity helper used by the serializer.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 9;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity_of(input logic [8:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit word buffer: power-of-two ring with first-word-fall-through read data
// and a registered occupancy count.
module uart_tx_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [W-1:0]          push_data_i,
  input  logic                  pop_i,
  output logic [W-1:0]          pop_data_o,
  output logic [DEPTH_BITS:0]   count_o
);

  localparam int                   DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]  CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]  CNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != CNT_FULL);
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready word intake into uart_tx_fifo, then a
// START/DATA/PARITY/STOP serializer with a reloading baud counter.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = PARITY_NONE,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BITS-1:0]       in_data,
  output logic                       tx,
  output logic                       tx_bsy,
  output logic [FIFO_DEPTH_BITS:0]   fifo_count,
  output uart_state_e                dbg_state
);

  if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2) || PARITY < 0 || PARITY > 2 ||
      DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_params
    $error("uart_tx_buffered: illegal parameter combination");
  end

  localparam int                       BAUD_W        = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]        BAUD_RELOAD   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]        BAUD_ONE      = BAUD_W'(1);
  localparam logic [3:0]               BIT_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]               BIT_LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [FIFO_DEPTH_BITS:0] FIFO_FULL     = (FIFO_DEPTH_BITS + 1)'(1 << FIFO_DEPTH_BITS);

  // Handshake: a word moves on a rising edge where in_valid && in_ready; in_ready
  // depends only on the registered count, and in_data must be stable while in_valid is high.
  uart_state_e              state_q, state_d;
  logic [BAUD_W-1:0]        baud_q, baud_d;
  logic [3:0]               bit_q, bit_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic                     par_q, par_d;
  logic                     tx_q, tx_d;
  logic                     avail_q;
  logic                     launch;
  logic [DATA_BITS-1:0]     fifo_data;
  logic [FIFO_DEPTH_BITS:0] fifo_cnt;

  uart_tx_fifo #(
    .W          (DATA_BITS),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid && in_ready),
    .push_data_i (in_data),
    .pop_i       (launch),
    .pop_data_o  (fifo_data),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    launch  = 1'b0;
    case (state_q)
      // An idle line starts from a one-cycle-old non-empty flag, giving a fixed
      // two-edge latency from the accepting edge to the start bit.
      S_IDLE: begin
        tx_d   = 1'b1;
        launch = avail_q && (fifo_cnt != '0);
      end
      default: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BAUD_ONE;
        end else begin
          baud_d = BAUD_RELOAD;
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              bit_d   = '0;
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
            end
            S_DATA: begin
              if (bit_q == BIT_LAST_DATA) begin
                bit_d = '0;
                if (PARITY != PARITY_NONE) begin
                  state_d = S_PARITY;
                  tx_d    = par_q;
                end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                end
              end else begin
                bit_d   = bit_q + 4'd1;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              bit_d   = '0;
              tx_d    = 1'b1;
            end
            S_STOP: begin
              if (bit_q != BIT_LAST_STOP) begin
                bit_d = bit_q + 4'd1;
                tx_d  = 1'b1;
              end else if (fifo_cnt != '0) begin
                launch = 1'b1;
              end else begin
                state_d = S_IDLE;
                bit_d   = '0;
                baud_d  = '0;
                tx_d    = 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
    if (launch) begin
      state_d = S_START;
      tx_d    = 1'b0;
      shift_d = fifo_data;
      par_d   = parity_of(9'(fifo_data), PARITY);
      baud_d  = BAUD_RELOAD;
      bit_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      avail_q <= (fifo_cnt != '0);
    end
  end

  assign tx         = tx_q;
  assign fifo_count = fifo_cnt;
  assign in_ready   = (fifo_cnt != FIFO_FULL);
  assign tx_bsy     = (state_q != S_IDLE) || (fifo_cnt != '0);
  assign dbg_state  = state_q;

endmodule
